// File: rtl/aexm_dbus_resp_if.sv
// Bus bundle between the aexm execute stage, the data responder and the memory port.
// Latency: none (wires only).
// Backpressure: carried by dstall (core side) and mem_rdy (memory side).
// Ports: core request (addr/stb/we/sel/dto) and response (rDWBDI/ack/err/dstall),
//        memory cycle (mem_addr/cs/we/be/wdat) and memory return (mem_rdat/mem_rdy).
interface aexm_dbus_resp_if #(
    parameter int AW = 30
);
    logic [AW-1:0] aexm_dcache_precycle_addr;
    logic          dwb_stb;
    logic          dwb_we;
    logic [3:0]    rDWBSEL;
    logic [31:0]   dwb_dto;
    logic [31:0]   rDWBDI;
    logic          dwb_ack;
    logic          dwb_err;
    logic          dstall;
    logic [AW-1:0] mem_addr;
    logic          mem_cs;
    logic          mem_we;
    logic [3:0]    mem_be;
    logic [31:0]   mem_wdat;
    logic [31:0]   mem_rdat;
    logic          mem_rdy;

    // master: the core plus the memory model driving the responder
    modport master (
        output aexm_dcache_precycle_addr, dwb_stb, dwb_we, rDWBSEL, dwb_dto,
        output mem_rdat, mem_rdy,
        input  rDWBDI, dwb_ack, dwb_err, dstall,
        input  mem_addr, mem_cs, mem_we, mem_be, mem_wdat
    );

    // slave: the responder itself
    modport slave (
        input  aexm_dcache_precycle_addr, dwb_stb, dwb_we, rDWBSEL, dwb_dto,
        input  mem_rdat, mem_rdy,
        output rDWBDI, dwb_ack, dwb_err, dstall,
        output mem_addr, mem_cs, mem_we, mem_be, mem_wdat
    );
endinterface

// File: rtl/aexm_dbus_resp.sv
// Data-side responder: runs one wait-stated memory access per core request, returns lane-extracted load data.
// Latency: ack 2 cycles after the stb edge with zero-wait memory, plus one cycle per wait state.
// Backpressure: dstall holds the core during ACCESS; stb in ACCESS is ignored; TMO bounds a stuck memory.
// Ports: gclk, grst (async active-low), bus (slave modport: core request/response and memory cycle).
module aexm_dbus_resp #(
    parameter int AW  = 30,
    parameter int TMO = 15
) (
    input logic             gclk,
    input logic             grst,
    aexm_dbus_resp_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t        state, state_d;
    logic [AW-1:0] addr_q;
    logic          we_q;
    logic [3:0]    sel_q;
    logic [31:0]   wdat_q;
    logic [7:0]    cnt;
    logic          first_q;
    logic [31:0]   rdata_q;
    logic          err_q;

    logic          in_acc;
    logic          we_e;
    logic [3:0]    sel_e;
    logic [31:0]   wdat_e;
    logic          mem_sel;
    logic          hit;
    logic          to_resp;

    function automatic logic [31:0] steer(input logic [31:0] d, input logic [3:0] s);
        case (s)
            4'h8, 4'h4, 4'h2, 4'h1: steer = {4{d[7:0]}};
            4'hC, 4'h3:             steer = {2{d[15:0]}};
            default:                steer = d;
        endcase
    endfunction

    function automatic logic [31:0] extract(input logic [31:0] r, input logic [3:0] s);
        case (s)
            4'h8:    extract = {24'h0, r[31:24]};
            4'h4:    extract = {24'h0, r[23:16]};
            4'h2:    extract = {24'h0, r[15:8]};
            4'h1:    extract = {24'h0, r[7:0]};
            4'hC:    extract = {16'h0, r[31:16]};
            4'h3:    extract = {16'h0, r[15:0]};
            default: extract = r;
        endcase
    endfunction

    // we/sel/dto only arrive in the first ACCESS cycle, so that cycle uses the live
    // inputs and later cycles use the copies latched at the end of it. This keeps the
    // memory cycle usable in the very first ACCESS cycle (zero-wait memory).
    always_comb begin
        in_acc  = (state == ACCESS);
        sel_e   = first_q ? bus.rDWBSEL : sel_q;
        we_e    = first_q ? bus.dwb_we  : we_q;
        wdat_e  = first_q ? steer(bus.dwb_dto, bus.rDWBSEL) : wdat_q;
        mem_sel = 1'b0;
        case (sel_e)
            4'h8, 4'h4, 4'h2, 4'h1, 4'hC, 4'h3, 4'hF: mem_sel = 1'b1;
            default:                                  mem_sel = 1'b0;
        endcase
        hit     = in_acc && mem_sel && bus.mem_rdy;
        // FSL and illegal selects never start a memory cycle and finish at once
        to_resp = !mem_sel || bus.mem_rdy || (cnt == 8'(TMO));

        state_d = state;
        case (state)
            IDLE:    if (bus.dwb_stb) state_d = ACCESS;
            ACCESS:  if (to_resp)     state_d = RESP;
            RESP:    state_d = bus.dwb_stb ? ACCESS : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge gclk or negedge grst) begin
        if (!grst) begin
            state   <= IDLE;
            addr_q  <= '0;
            we_q    <= 1'b0;
            sel_q   <= 4'h0;
            wdat_q  <= 32'h0;
            cnt     <= 8'h0;
            first_q <= 1'b0;
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
        end else begin
            state <= state_d;
            if (in_acc) begin
                first_q <= 1'b0;
                if (first_q) begin
                    we_q   <= bus.dwb_we;
                    sel_q  <= bus.rDWBSEL;
                    wdat_q <= wdat_e;
                end
                if (!hit) cnt <= cnt + 8'd1;
                if (state_d == RESP) begin
                    // anything other than a completed memory cycle returns zero data
                    rdata_q <= hit ? extract(bus.mem_rdat, sel_e) : 32'h0;
                    err_q   <= !hit && (sel_e != 4'h0);
                end
            end else if (state_d == ACCESS) begin
                addr_q  <= bus.aexm_dcache_precycle_addr;
                first_q <= 1'b1;
                cnt     <= 8'h0;
            end
        end
    end

    assign bus.dstall   = in_acc;
    assign bus.dwb_ack  = (state == RESP);
    assign bus.dwb_err  = (state == RESP) && err_q;
    assign bus.rDWBDI   = rdata_q;
    assign bus.mem_addr = addr_q;
    assign bus.mem_cs   = in_acc && mem_sel;
    assign bus.mem_we   = in_acc && we_e;
    assign bus.mem_be   = in_acc ? sel_e  : 4'h0;
    assign bus.mem_wdat = in_acc ? wdat_e : 32'h0;
endmodule

// File: tb/tb_aexm_dbus_resp.sv
module tb_aexm_dbus_resp;
    localparam int AW  = 30;
    localparam int TMO = 15;

    logic gclk = 1'b0;
    logic grst;
    int   checks   = 0;
    int   failures = 0;

    aexm_dbus_resp_if #(.AW(AW)) bus();

    aexm_dbus_resp #(.AW(AW), .TMO(TMO)) dut (
        .gclk (gclk),
        .grst (grst),
        .bus  (bus)
    );

    always #5 gclk = ~gclk;

    // ---------------- reference model (transaction level) ----------------
    function automatic bit sel_mem(input logic [3:0] s);
        return ($countones(s) == 1) || (s == 4'h3) || (s == 4'hC) || (s == 4'hF);
    endfunction

    function automatic logic [31:0] exp_load(input logic [31:0] r, input logic [3:0] s);
        int lane;
        lane = 0;
        if (s == 4'hF) return r;
        if (s == 4'h3) return r & 32'h0000FFFF;
        if (s == 4'hC) return r >> 16;
        for (int i = 0; i < 4; i++) if (s[i]) lane = i;
        return (r >> (8 * lane)) & 32'h000000FF;
    endfunction

    function automatic logic [31:0] exp_wdat(input logic [31:0] d, input logic [3:0] s);
        if (s == 4'hF) return d;
        if (s == 4'h3 || s == 4'hC) return (d & 32'h0000FFFF) * 32'h00010001;
        return (d & 32'h000000FF) * 32'h01010101;
    endfunction

    task automatic step();
        @(posedge gclk);
        #1;
    endtask

    // One access. waits<0 means mem_rdy never comes. pre_stb: stb already taken in the
    // previous RESP cycle. chain: present next_addr with stb during this RESP cycle.
    task automatic run_txn(input string name, input logic [AW-1:0] addr, input logic we,
                           input logic [3:0] sel, input logic [31:0] dto, input logic [31:0] rdat,
                           input int waits, input bit pre_stb, input bit chain,
                           input logic [AW-1:0] next_addr, input bit hold_stb);
        bit          cs_exp, timed_out, exp_err, got_ack, chk_rd;
        int          exp_acc, acc;
        logic [31:0] exp_rd;
        cs_exp    = sel_mem(sel);
        timed_out = cs_exp && (waits < 0 || waits > TMO);
        exp_acc   = !cs_exp ? 1 : (timed_out ? TMO + 1 : waits + 1);
        exp_err   = (sel != 4'h0) && (!cs_exp || timed_out);
        exp_rd    = (cs_exp && !timed_out) ? exp_load(rdat, sel) : 32'h0;
        chk_rd    = !we || !cs_exp;

        if (!pre_stb) begin
            bus.dwb_stb = 1'b1;
            bus.aexm_dcache_precycle_addr = addr;
            bus.mem_rdy = 1'b0;
            step();
        end
        bus.dwb_stb = hold_stb;
        acc = 0;
        got_ack = 0;
        for (int cyc = 0; cyc < TMO + 8 && !got_ack; cyc++) begin
            if (bus.dwb_ack === 1'b1) begin
                got_ack = 1;
            end else begin
                if (acc == 0) begin
                    bus.dwb_we = we; bus.rDWBSEL = sel; bus.dwb_dto = dto;
                end else begin
                    bus.dwb_we = 1'($urandom); bus.rDWBSEL = 4'($urandom); bus.dwb_dto = $urandom;
                end
                bus.mem_rdy  = (acc == waits);
                bus.mem_rdat = (acc == waits) ? rdat : $urandom;
                bus.aexm_dcache_precycle_addr = AW'($urandom);
                #1;
                checks++;
                if (bus.dstall !== 1'b1) begin
                    failures++; $display("FAIL %s_dstall acc=%0d got=%b exp=1", name, acc, bus.dstall);
                end
                checks++;
                if (bus.mem_cs !== cs_exp) begin
                    failures++; $display("FAIL %s_mem_cs acc=%0d got=%b exp=%b", name, acc, bus.mem_cs, cs_exp);
                end
                if (cs_exp) begin
                    checks++;
                    if (bus.mem_addr !== addr) begin
                        failures++; $display("FAIL %s_mem_addr got=%h exp=%h", name, bus.mem_addr, addr);
                    end
                    checks++;
                    if (bus.mem_we !== we) begin
                        failures++; $display("FAIL %s_mem_we got=%b exp=%b", name, bus.mem_we, we);
                    end
                    checks++;
                    if (bus.mem_be !== sel) begin
                        failures++; $display("FAIL %s_mem_be got=%h exp=%h", name, bus.mem_be, sel);
                    end
                    checks++;
                    if (bus.mem_wdat !== exp_wdat(dto, sel)) begin
                        failures++; $display("FAIL %s_mem_wdat acc=%0d got=%h exp=%h", name, acc, bus.mem_wdat, exp_wdat(dto, sel));
                    end
                end
                acc++;
                step();
            end
        end

        checks++;
        if (!got_ack) begin
            failures++; $display("FAIL %s_no_ack got=none exp=ack within %0d cycles", name, TMO + 8);
        end else begin
            checks++;
            if (acc != exp_acc) begin
                failures++; $display("FAIL %s_access_cycles got=%0d exp=%0d", name, acc, exp_acc);
            end
            checks++;
            if (bus.dwb_err !== exp_err) begin
                failures++; $display("FAIL %s_err got=%b exp=%b", name, bus.dwb_err, exp_err);
            end
            if (chk_rd) begin
                checks++;
                if (bus.rDWBDI !== exp_rd) begin
                    failures++; $display("FAIL %s_rdata got=%h exp=%h", name, bus.rDWBDI, exp_rd);
                end
            end
            checks++;
            if (bus.mem_cs !== 1'b0 || bus.dstall !== 1'b0) begin
                failures++; $display("FAIL %s_resp_idle got cs=%b stall=%b exp=0/0", name, bus.mem_cs, bus.dstall);
            end
            bus.mem_rdy = 1'b0;
            if (chain) begin
                bus.dwb_stb = 1'b1;
                bus.aexm_dcache_precycle_addr = next_addr;
            end else begin
                bus.dwb_stb = 1'b0;
            end
            step();
            if (!chain) begin
                checks++;
                if (bus.dwb_ack !== 1'b0 || bus.dstall !== 1'b0) begin
                    failures++; $display("FAIL %s_after got ack=%b stall=%b exp=0/0", name, bus.dwb_ack, bus.dstall);
                end
                if (chk_rd) begin
                    checks++;
                    if (bus.rDWBDI !== exp_rd) begin
                        failures++; $display("FAIL %s_rdata_hold got=%h exp=%h", name, bus.rDWBDI, exp_rd);
                    end
                end
            end
        end
    endtask

    task automatic idle_no_ack(input string name, input int n);
        for (int i = 0; i < n; i++) begin
            step();
            checks++;
            if (bus.dwb_ack !== 1'b0 || bus.dstall !== 1'b0 || bus.mem_cs !== 1'b0) begin
                failures++;
                $display("FAIL %s cyc=%0d got ack=%b stall=%b cs=%b exp=0/0/0", name, i, bus.dwb_ack, bus.dstall, bus.mem_cs);
            end
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        grst = 1'b0;
        bus.dwb_stb = 1'b0; bus.dwb_we = 1'b0; bus.rDWBSEL = 4'h0; bus.dwb_dto = 32'h0;
        bus.aexm_dcache_precycle_addr = '0; bus.mem_rdat = 32'h0; bus.mem_rdy = 1'b0;
        step();
        checks++;
        if (bus.dstall !== 1'b0 || bus.dwb_ack !== 1'b0 || bus.dwb_err !== 1'b0 || bus.rDWBDI !== 32'h0) begin
            failures++;
            $display("FAIL reset_core got stall=%b ack=%b err=%b rd=%h exp=0", bus.dstall, bus.dwb_ack, bus.dwb_err, bus.rDWBDI);
        end
        checks++;
        if (bus.mem_cs !== 1'b0 || bus.mem_we !== 1'b0 || bus.mem_be !== 4'h0 ||
            bus.mem_addr !== '0 || bus.mem_wdat !== 32'h0) begin
            failures++;
            $display("FAIL reset_mem got cs=%b we=%b be=%h addr=%h wdat=%h exp=0",
                     bus.mem_cs, bus.mem_we, bus.mem_be, bus.mem_addr, bus.mem_wdat);
        end
        grst = 1'b1;
        idle_no_ack("reset_idle", 2);
    endtask

    task automatic test_word_load();
        run_txn("word_load", 30'h0000100, 1'b0, 4'hF, $urandom, 32'h11223344, 0, 0, 0, '0, 0);
        checks++;
        if (bus.rDWBDI !== 32'h11223344) begin
            failures++; $display("FAIL word_load_const got=%h exp=11223344", bus.rDWBDI);
        end
    endtask

    task automatic test_byte_loads();
        logic [3:0]  sels [6] = '{4'h8, 4'h4, 4'h2, 4'h1, 4'hC, 4'h3};
        logic [31:0] tab  [6] = '{32'hAA, 32'hBB, 32'hCC, 32'hDD, 32'hAABB, 32'hCCDD};
        for (int i = 0; i < 6; i++) begin
            run_txn("byte_load", AW'($urandom), 1'b0, sels[i], $urandom, 32'hAABBCCDD,
                    int'($urandom_range(0, 2)), 0, 0, '0, 0);
            checks++;
            if (bus.rDWBDI !== tab[i]) begin
                failures++; $display("FAIL byte_load_const sel=%h got=%h exp=%h", sels[i], bus.rDWBDI, tab[i]);
            end
        end
    endtask

    task automatic test_byte_store();
        run_txn("byte_store", 30'h0000200, 1'b1, 4'h2, 32'h0000005A, $urandom, 3, 0, 0, '0, 0);
    endtask

    task automatic test_back_to_back();
        run_txn("b2b_first", 30'h0000300, 1'b0, 4'hF, $urandom, 32'hCAFEF00D, 0, 0, 1, 30'h0000304, 0);
        run_txn("b2b_second", 30'h0000304, 1'b0, 4'h1, $urandom, 32'h01020304, 0, 1, 0, '0, 0);
        run_txn("stb_held", 30'h0000308, 1'b0, 4'hC, $urandom, 32'h89ABCDEF, 2, 0, 0, '0, 1);
        idle_no_ack("stb_held_extra", 3);
    endtask

    task automatic test_timeout();
        run_txn("timeout", 30'h0000400, 1'b0, 4'hF, $urandom, 32'h55555555, -1, 0, 0, '0, 0);
        bus.mem_rdy = 1'b1;
        bus.mem_rdat = 32'h12345678;
        step();
        bus.mem_rdy = 1'b0;
        idle_no_ack("late_rdy", 4);
    endtask

    task automatic test_edge_sel();
        run_txn("sel0", 30'h0000500, 1'b0, 4'h0, $urandom, 32'hFFFFFFFF, 0, 0, 0, '0, 0);
        run_txn("sel5", 30'h0000504, 1'b0, 4'h5, $urandom, 32'hFFFFFFFF, 0, 0, 0, '0, 0);
    endtask

    task automatic test_reset_mid();
        bus.dwb_stb = 1'b1;
        bus.aexm_dcache_precycle_addr = 30'h0000600;
        step();
        bus.dwb_stb = 1'b0; bus.dwb_we = 1'b0; bus.rDWBSEL = 4'hF; bus.mem_rdy = 1'b0;
        step();
        #2;
        grst = 1'b0;
        #1;
        checks++;
        if (bus.mem_cs !== 1'b0 || bus.dstall !== 1'b0 || bus.dwb_ack !== 1'b0 || bus.rDWBDI !== 32'h0) begin
            failures++;
            $display("FAIL reset_mid got cs=%b stall=%b ack=%b rd=%h exp=0", bus.mem_cs, bus.dstall, bus.dwb_ack, bus.rDWBDI);
        end
        step();
        grst = 1'b1;
        bus.mem_rdy = 1'b1;
        idle_no_ack("reset_mid_release", 4);
        bus.mem_rdy = 1'b0;
    endtask

    task automatic test_random();
        logic [3:0]    pool [9] = '{4'h8, 4'h4, 4'h2, 4'h1, 4'hC, 4'h3, 4'hF, 4'h0, 4'h6};
        bit            pend, chain;
        logic [AW-1:0] addr, naddr;
        int            waits;
        logic [3:0]    sel;
        pend = 0;
        addr = AW'($urandom);
        for (int i = 0; i < 40; i++) begin
            sel   = ($urandom_range(0, 9) == 0) ? pool[$urandom_range(7, 8)] : pool[$urandom_range(0, 6)];
            waits = ($urandom_range(0, 15) == 0) ? -1 : int'($urandom_range(0, 5));
            chain = ($urandom_range(0, 2) == 0) && (i < 39);
            naddr = AW'($urandom);
            run_txn("random", addr, 1'($urandom), sel, $urandom, $urandom, waits, pend, chain, naddr, 0);
            pend = chain;
            addr = chain ? naddr : AW'($urandom);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=no finish exp=finish before 200000");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_word_load();
        test_byte_loads();
        test_byte_store();
        test_back_to_back();
        test_timeout();
        test_edge_sel();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
